// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-side memory subsystem.
//   - MMIO page base and register offsets (byte offsets within the page)
//   - UART_STAT bit positions
//   - UART transmitter FSM state type
package data_mem_pkg;

  localparam logic [23:0] MMIO_PAGE     = 24'h100000;  // i_addr[31:8] of the MMIO page
  localparam logic [7:0]  OFF_UART_DATA = 8'h00;
  localparam logic [7:0]  OFF_UART_STAT = 8'h04;
  localparam logic [7:0]  OFF_LED       = 8'h08;
  localparam logic [7:0]  OFF_CYCLE_LO  = 8'h0C;
  localparam logic [7:0]  OFF_CYCLE_HI  = 8'h10;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 3;
  localparam int STAT_OVF   = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;

endpackage

// File: rtl/data_mem_bus_uart_tx.sv
// UART transmitter: byte FIFO, baud counter and 8N1 framing FSM.
// Ports:
//   clk, rstn       clock, async active-low reset
//   push, push_data enqueue one byte (accepted when not full, or when a pop
//                   happens in the same cycle)
//   full, empty     FIFO status
//   busy            a frame is in flight (FSM not idle)
//   tx              serial line, idle high
module uart_tx
  import data_mem_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [7:0]     fifo [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  uart_tx_state_t state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           pop, accept, bit_done;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign busy     = (state != TX_IDLE);
  assign pop      = (state == TX_IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept   = push && (!full || pop);
  assign bit_done = (baud_cnt == BAUD_LAST);

  // Line is decoded straight from registered state so reset forces it high at once.
  assign tx = (state == TX_START) ? 1'b0 :
              (state == TX_DATA)  ? shreg[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      // Counter parks at 0 in IDLE so every bit, START included, is BAUD_DIV cycles.
      baud_cnt <= (state == TX_IDLE || bit_done) ? '0 : baud_cnt + 1'b1;
      case (state)
        TX_IDLE: if (!empty) begin
          state <= TX_START;
          shreg <= fifo[rd_ptr];
        end
        TX_START: if (bit_done) begin
          state   <= TX_DATA;
          bit_idx <= '0;
        end
        TX_DATA: if (bit_done) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= TX_STOP;
        end
        TX_STOP: if (bit_done) state <= TX_IDLE;
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_bus.sv
// Data-side memory subsystem behind the core's load/store stage.
// Word RAM at 0x0 plus an MMIO page at 0x1000_00xx (UART, LED, cycle counter).
// Load data is combinational from the address; stores commit on the clock edge.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   i_addr                    byte address, bits [1:0] ignored
//   i_write_data              store data
//   i_read_en, i_write_en     load / store strobes
//   o_read_data               load data, 0 when i_read_en is low
//   o_uart_tx                 UART 8N1 line
//   o_led                     LED register
module data_mem_bus
  import data_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic        i_read_en,
  input  logic        i_write_en,
  output logic [31:0] o_read_data,
  output logic        o_uart_tx,
  output logic [7:0]  o_led
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;  // expected >= 2
  localparam int AW       = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_sel, mmio_sel;
  logic [7:0]    reg_off;
  logic [63:0]   cycle_cnt;
  logic [31:0]   cycle_hi;
  logic          overflow;
  logic          uart_push, uart_full, uart_empty, uart_busy;
  logic          ovf_set, ovf_clr;
  logic [31:0]   stat;
  logic          unused;

  assign unused   = &{1'b0, i_addr[1:0]};
  assign ram_idx  = i_addr[2 +: AW];
  assign ram_sel  = (i_addr[31:AW+2] == '0);
  assign mmio_sel = (i_addr[31:8] == MMIO_PAGE);
  assign reg_off  = {i_addr[7:2], 2'b00};

  assign uart_push = i_write_en && mmio_sel && (reg_off == OFF_UART_DATA);
  // Full FIFO drops the byte unless the transmitter pops this cycle; a pop only
  // happens from idle, so a full FIFO with the FSM busy is a true drop.
  assign ovf_set   = uart_push && uart_full && uart_busy;
  assign ovf_clr   = i_write_en && mmio_sel && (reg_off == OFF_UART_STAT) &&
                     i_write_data[STAT_OVF];

  uart_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) u_uart (
    .clk       (clk),
    .rstn      (rstn),
    .push      (uart_push),
    .push_data (i_write_data[7:0]),
    .full      (uart_full),
    .empty     (uart_empty),
    .busy      (uart_busy),
    .tx        (o_uart_tx)
  );

  always_ff @(posedge clk) begin
    if (i_write_en && ram_sel) ram[ram_idx] <= i_write_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_led     <= '0;
      cycle_cnt <= '0;
      cycle_hi  <= '0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      // Snapshot the upper half on a low-half load so the pair reads coherently.
      if (i_read_en && mmio_sel && reg_off == OFF_CYCLE_LO) cycle_hi <= cycle_cnt[63:32];
      if (i_write_en && mmio_sel && reg_off == OFF_LED) o_led <= i_write_data[7:0];
      overflow <= ovf_set | (overflow & ~ovf_clr);  // set wins over clear
    end
  end

  always_comb begin
    stat             = '0;
    stat[STAT_FULL]  = uart_full;
    stat[STAT_EMPTY] = uart_empty;
    stat[STAT_BUSY]  = uart_busy;
    stat[STAT_OVF]   = overflow;
  end

  always_comb begin
    o_read_data = '0;
    if (i_read_en) begin
      if (ram_sel) o_read_data = ram[ram_idx];
      else if (mmio_sel) begin
        case (reg_off)
          OFF_UART_STAT: o_read_data = stat;
          OFF_LED:       o_read_data = {24'b0, o_led};
          OFF_CYCLE_LO:  o_read_data = cycle_cnt[31:0];
          OFF_CYCLE_HI:  o_read_data = cycle_hi;
          default:       o_read_data = '0;
        endcase
      end
    end
  end

endmodule
